// File: rtl/data_memory_sized.sv
// Sized data memory for the MEM stage: byte/half/word loads and stores,
// misalign detect, post-reset clear sweep. Optional image port: DMEM_DEBUG_EN.
module data_memory_sized #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_read,
  input  logic              i_wenable,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [31:0]       i_data,
  output logic [31:0]       o_data,
  output logic              o_misaligned,
  output logic              o_busy
`ifdef DMEM_DEBUG_EN
  ,
  output logic [32*DEPTH-1:0] o_data_to_debug
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  logic [31:0]      mem [DEPTH];
  state_t           state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n;

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             is_b, is_h, is_w;
  logic             mis, access;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  logic [31:0]      rword, load_val;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;

  // Address bits above the array are ignored: accesses wrap.
  logic             unused_addr;
  assign unused_addr = ^i_address[ADDR_W-1:IDX_W+2];

  assign idx    = i_address[IDX_W+1:2];
  assign lane   = i_address[1:0];
  assign access = i_read | i_wenable;
  assign o_busy = (state == CLEAR);

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    unique case (1'b1)
      (i_size == 2'b00): is_b = 1'b1;
      (i_size == 2'b01): is_h = 1'b1;
      default:           is_w = 1'b1;
    endcase
  end

  assign mis = (is_h & lane[0]) | (is_w & (|lane));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == CLEAR) begin
      cnt_n = cnt + 1'b1;
      if (cnt == IDX_W'(DEPTH - 1))
        state_n = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // One shared write port: clear sweep or a lane-masked store.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_be   = 4'b0000;
    wr_data = 32'h0;
    if (state == CLEAR) begin
      wr_en  = 1'b1;
      wr_idx = cnt;
      wr_be  = 4'b1111;
    end else if (i_wenable && !mis) begin
      wr_en = 1'b1;
      unique case (1'b1)
        is_b: begin
          wr_be   = 4'b0001 << lane;
          wr_data = {4{i_data[7:0]}};
        end
        is_h: begin
          wr_be   = lane[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{i_data[15:0]}};
        end
        default: begin
          wr_be   = 4'b1111;
          wr_data = i_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rword = mem[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = rword;
    unique case (1'b1)
      is_b:    load_val = {{24{~i_unsigned & rbyte[7]}}, rbyte};
      is_h:    load_val = {{16{~i_unsigned & rhalf[15]}}, rhalf};
      default: load_val = rword;
    endcase
  end

  // Falling-edge read: sees the store made at the preceding rising edge.
  always_ff @(negedge clk) begin
    if (state == CLEAR) begin
      o_data       <= 32'h0;
      o_misaligned <= 1'b0;
    end else begin
      o_misaligned <= mis & access;
      if (i_read)
        o_data <= mis ? 32'h0 : load_val;
    end
  end

`ifdef DMEM_DEBUG_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_dbg
    assign o_data_to_debug[32*(DEPTH-g)-1 -: 32] = mem[g];
  end
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized (DEPTH=32).
// Ops are driven after a falling edge and sampled after the next one.
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_read;
  logic        i_wenable;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_address;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_misaligned;
  logic        o_busy;
`ifdef DMEM_DEBUG_EN
  logic [1023:0] o_data_to_debug;
`endif

  int passed = 0;
  int total  = 0;
  int n;

  always #5 clk = ~clk;

  data_memory_sized #(.DEPTH(32), .ADDR_W(32)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_read       (i_read),
    .i_wenable    (i_wenable),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_address    (i_address),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_misaligned (o_misaligned),
    .o_busy       (o_busy)
`ifdef DMEM_DEBUG_EN
    ,
    .o_data_to_debug (o_data_to_debug)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic op(input logic rd, input logic we, input logic [1:0] sz,
                    input logic uns, input logic [31:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    #1;
    i_read     = rd;
    i_wenable  = we;
    i_size     = sz;
    i_unsigned = uns;
    i_address  = a;
    i_data     = d;
    @(posedge clk);
    @(negedge clk);
    #1;
    i_read    = 1'b0;
    i_wenable = 1'b0;
  endtask

  initial begin
    i_reset    = 1'b1;
    i_read     = 1'b0;
    i_wenable  = 1'b0;
    i_size     = 2'b10;
    i_unsigned = 1'b0;
    i_address  = 32'h0;
    i_data     = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_data", o_data, 32'h0);
    check("rst_mis", {31'b0, o_misaligned}, 32'h0);
    check("rst_busy", {31'b0, o_busy}, 32'h1);

    i_reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (o_busy && n < 40);
    check("clear_edges", n, 32);

    for (int a = 0; a < 128; a += 4) begin
      op(1, 0, 2'b10, 0, a, 0);
      check($sformatf("clr_lw_%0h", a), o_data, 32'h0);
    end

    op(0, 1, 2'b10, 0, 32'h08, 32'h8765_43A1);
    op(1, 0, 2'b00, 0, 32'h08, 0);
    check("lb_08", o_data, 32'hFFFF_FFA1);
    op(1, 0, 2'b00, 1, 32'h08, 0);
    check("lbu_08", o_data, 32'h0000_00A1);
    op(1, 0, 2'b01, 0, 32'h0A, 0);
    check("lh_0a", o_data, 32'hFFFF_8765);
    op(1, 0, 2'b01, 1, 32'h0A, 0);
    check("lhu_0a", o_data, 32'h0000_8765);
    op(1, 0, 2'b11, 1, 32'h08, 0);
    check("lw11_08", o_data, 32'h8765_43A1);
    op(1, 0, 2'b00, 0, 32'h09, 0);
    check("lb_09", o_data, 32'h0000_0043);

    op(0, 1, 2'b10, 0, 32'h10, 32'h0);
    op(0, 1, 2'b00, 0, 32'h13, 32'h0000_00FF);
    op(0, 1, 2'b01, 0, 32'h10, 32'h0000_1234);
    op(1, 0, 2'b10, 0, 32'h10, 0);
    check("partial_lw", o_data, 32'hFF00_1234);

    op(0, 1, 2'b10, 0, 32'h06, 32'hDEAD_BEEF);
    check("sw06_mis", {31'b0, o_misaligned}, 32'h1);
    op(1, 0, 2'b10, 0, 32'h04, 0);
    check("sw06_unch", o_data, 32'h0);
    check("lw04_mis", {31'b0, o_misaligned}, 32'h0);
    op(1, 0, 2'b10, 0, 32'h08, 0);
    op(1, 0, 2'b01, 0, 32'h05, 0);
    check("lh05_data", o_data, 32'h0);
    check("lh05_mis", {31'b0, o_misaligned}, 32'h1);
    op(1, 0, 2'b00, 0, 32'h05, 0);
    check("lb05_mis", {31'b0, o_misaligned}, 32'h0);

    op(0, 1, 2'b10, 0, 32'h80, 32'hCAFE_BABE);
    op(1, 0, 2'b10, 0, 32'h00, 0);
    check("wrap_lw00", o_data, 32'hCAFE_BABE);

    op(1, 1, 2'b10, 0, 32'h04, 32'h1111_1111);
    check("rw_same", o_data, 32'h1111_1111);
    op(0, 0, 2'b10, 0, 32'h08, 0);
    check("hold", o_data, 32'h1111_1111);

`ifdef DMEM_DEBUG_EN
    op(0, 1, 2'b10, 0, 32'h00, 32'hA5A5_A5A5);
    check("dbg_w0", o_data_to_debug[1023:992], 32'hA5A5_A5A5);
    check("dbg_w1", o_data_to_debug[991:960], 32'h1111_1111);
`endif

    @(negedge clk);
    #1;
    i_reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst2_data", o_data, 32'h0);
    check("rst2_busy", {31'b0, o_busy}, 32'h1);
    i_reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 20) begin
        i_wenable = 1'b1;
        i_size    = 2'b10;
        i_address = 32'h00;
        i_data    = 32'h5555_5555;
      end
      if (n == 21)
        i_wenable = 1'b0;
    end while (o_busy && n < 40);
    i_wenable = 1'b0;
    check("mid_edges", n, 32);
    op(1, 0, 2'b10, 0, 32'h00, 0);
    check("mid_lw00", o_data, 32'h0);
    op(1, 0, 2'b10, 0, 32'h08, 0);
    check("mid_lw08", o_data, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Parametrised data memory for the MIPS pipeline MEM stage, successor to the fixed 32-word word-only data memory. Adds byte/halfword/word accesses with sign or zero extension, configurable depth, misalignment detection, and a hardware clear sequence after reset that zeroes the array one word per cycle. It sits between the EX/MEM and MEM/WB latches. The optional flattened debug dump feeds the debug unit's UART transmitter.

## Interface
- `DEPTH`, 32: number of 32-bit words; power of two, at least 4.
- `ADDR_W`, 32: width of the byte address input.
- `IDX_W`, log2(`DEPTH`) (localparam): word index width.
- `clk` in 1: single clock. Writes happen on the rising edge; the read register updates on the falling edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_read` in 1: load request.
- `i_wenable` in 1: store request.
- `i_size` in 2: access size. 00 = byte, 01 = half, 10 = word. 11 is treated as word.
- `i_unsigned` in 1: on loads, 1 = zero-extend, 0 = sign-extend.
- `i_address` in `ADDR_W`: byte address.
- `i_data` in 32: store data, right-aligned.
- `o_data` out 32: load data, extended to 32 bits.
- `o_misaligned` out 1: the current access is misaligned.
- `o_busy` out 1: clear sequence in progress.
- `o_data_to_debug` out 32*`DEPTH`: full memory image. Present only with `DMEM_DEBUG_EN`.

## Operation
- **Addressing.**
  - Word index = `i_address[IDX_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4*`DEPTH`.
  - Lane = `i_address[1:0]`.
  - Byte order is little-endian: lane 0 = bits [7:0]; a half at `addr[1]`=1 occupies bits [31:16].
- **Alignment.** An access is misaligned when it is a half with `addr[0]`=1, or a word with `addr[1:0]`≠0. Byte accesses are never misaligned.
- **Stores.** With `i_wenable`=1, not misaligned, and state READY, only the addressed lanes are written from the low bits of `i_data`. All other lanes are preserved.
- **Loads.**
  - The addressed lanes are extracted, then sign- or zero-extended per `i_unsigned`.
  - A word load ignores `i_unsigned`.
  - If `i_read`=0, `o_data` holds its previous value.
- **Misaligned access.**
  - Store is suppressed.
  - Load returns 0.
  - `o_misaligned`=1 only when `i_read` or `i_wenable` is 1.
- **Simultaneous `i_read` and `i_wenable`.** The write happens at the rising edge. The read at the following falling edge returns the newly written value.
- **State machine.**
  - CLEAR:
    - Entered on any cycle with `i_reset`=1, which also loads the clear counter to 0.
    - Each rising edge with `i_reset`=0 writes 0 to `mem[counter]` and increments the counter.
    - After writing index `DEPTH`-1, go to READY.
    - In CLEAR, `o_busy`=1, stores are ignored and `o_data` is forced to 0.
  - READY: normal operation. `o_busy`=0.
  - Reset asserted mid-sweep restarts the sweep at index 0.
- **Reset values.** `o_data`=0, `o_misaligned`=0, `o_busy`=1.

## Timing
- **Store latency.** The array is updated at the rising edge where the request is sampled.
- **Load latency.** `o_data` and `o_misaligned` are registered on the falling edge of the same cycle. They are stable for the MEM/WB latch at the next rising edge (half-cycle latency).
- **Clear duration.** Exactly `DEPTH` rising edges after the first edge with `i_reset`=0.
  - `o_busy` falls at the edge that writes the last word.
  - The first accepted store is on the following edge.
- **Reset application.** `i_reset` is sampled only at the rising edge. The falling-edge read register clears at the first falling edge after `i_reset` is sampled high.
- **Pipeline stall.** The pipeline must stall while `o_busy`=1. The block performs no request queuing.

## Configuration
- `DMEM_DEBUG_EN` defined:
  - `o_data_to_debug` = {mem[0], mem[1], …, mem[`DEPTH`-1]}, with mem[0] in the most significant 32 bits.
  - The value is combinational from the array.
- `DMEM_DEBUG_EN` undefined:
  - The port does not exist.
  - The array has no parallel read path, so it infers as block RAM.
  - All other behaviour is identical.

## Test plan
- **Reset and clear.** Release `i_reset` with `DEPTH`=32.
  - `o_busy` is high for exactly 32 rising edges.
  - Afterwards, word loads at 0x00 to 0x7C all return 0x00000000.
- **Store word, load byte/half.**
  - `sw` 0x8765_43A1 to 0x08.
  - `lb` 0x08 → 0xFFFFFFA1; `lbu` 0x08 → 0x000000A1.
  - `lh` 0x0A → 0xFFFF8765; `lhu` 0x0A → 0x00008765.
- **Partial stores.** `sw` 0x0 to 0x10, then `sb` 0xFF to 0x13, then `sh` 0x1234 to 0x10. `lw` 0x10 → 0xFF001234.
- **Misalignment.**
  - `sw` to 0x06 → `o_misaligned`=1, memory unchanged.
  - `lh` at 0x05 → `o_data`=0, `o_misaligned`=1.
  - `lb` at 0x05 → `o_misaligned`=0.
- **Wrap and same-cycle read/write.**
  - `sw` 0xCAFEBABE to 0x80 (`DEPTH`=32), then `lw` 0x00 → 0xCAFEBABE.
  - Read and write of 0x04 in the same cycle with 0x11111111 → `o_data`=0x11111111.
- **Reset mid-sweep and debug.**
  - Reassert `i_reset` at sweep index 10 → sweep restarts, `o_busy` is high for 32 more edges.
  - With `DMEM_DEBUG_EN`, after `sw` 0xA5A5A5A5 to 0x00, `o_data_to_debug[1023:992]`=0xA5A5A5A5.
